// File: rtl/dual_rail_checker_2bit.sv
// Receive side of the 2-bit complementary-pair link: checks each codeword,
// buffers decoded data in a 2-entry FIFO and tracks errors / fault lockout.
module dual_rail_checker_2bit #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned FAULT_THRESH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       in_word,
  output logic             in_ready,
  output logic             out_valid,
  output logic [1:0]       out_data,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       last_bad,
  output logic             fault
);

  localparam int unsigned DEPTH    = 2;
  localparam int unsigned CONSEC_W = 4;
  localparam int unsigned DATA_W   = 2;

  typedef enum logic {RUN, FAULT} state_t;

  state_t                state_q, state_d;
  logic [CONSEC_W-1:0]   consec_q, consec_d;
  logic                  err_flag_q, err_flag_d;
  logic [CNT_W-1:0]      err_count_q, err_count_d;
  logic [3:0]            last_bad_q, last_bad_d;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;

  logic                  accept;
  logic                  word_ok;
  logic                  push;
  logic                  pop;
  logic [CONSEC_W-1:0]   consec_inc;

  assign word_ok    = (in_word[3:2] == ~in_word[1:0]);
  assign in_ready   = (state_q == RUN) && (count_q < 2'(DEPTH));
  assign accept     = in_valid && in_ready;
  assign push       = accept && word_ok;
  assign pop        = out_valid && out_ready;
  assign consec_inc = (consec_q == CONSEC_W'(FAULT_THRESH)) ? consec_q : consec_q + CONSEC_W'(1);

  assign out_valid  = (count_q != 2'd0);
  assign out_data   = mem_q[rd_ptr_q];
  assign err_flag   = err_flag_q;
  assign err_count  = err_count_q;
  assign last_bad   = last_bad_q;
  assign fault      = (state_q == FAULT);

  // State and error bookkeeping; a clear overrides any error recorded this cycle.
  always_comb begin
    state_d     = state_q;
    consec_d    = consec_q;
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    last_bad_d  = last_bad_q;
    if (push) begin
      consec_d = '0;
    end else if (accept) begin
      err_flag_d = 1'b1;
      last_bad_d = in_word;
      consec_d   = consec_inc;
      if (err_count_q != {CNT_W{1'b1}}) err_count_d = err_count_q + CNT_W'(1);
      if (consec_inc == CONSEC_W'(FAULT_THRESH)) state_d = FAULT;
    end
    if (clr_err) begin
      state_d     = RUN;
      consec_d    = '0;
      err_flag_d  = 1'b0;
      err_count_d = '0;
      last_bad_d  = '0;
    end
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      consec_q    <= '0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
      last_bad_q  <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
    end else begin
      state_q     <= state_d;
      consec_q    <= consec_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
      last_bad_q  <= last_bad_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      if (push) mem_q[wr_ptr_q] <= in_word[3:2];
    end
  end

endmodule

// File: tb/tb_dual_rail_checker_2bit.sv
// Directed bench for dual_rail_checker_2bit: queue-based reference model
// checked every cycle, plus hand-computed literal checks at key points.
module tb_dual_rail_checker_2bit;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned THRESH = 3;
  localparam int unsigned CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [3:0]       in_word;
  logic             in_ready;
  logic             out_valid;
  logic [1:0]       out_data;
  logic             out_ready;
  logic             clr_err;
  logic             err_flag;
  logic [CNT_W-1:0] err_count;
  logic [3:0]       last_bad;
  logic             fault;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_q[$];
  int m_cnt, m_consec, m_last;
  bit m_flag, m_fault;

  dual_rail_checker_2bit #(.CNT_W(CNT_W), .FAULT_THRESH(THRESH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_word(in_word),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .clr_err(clr_err), .err_flag(err_flag),
    .err_count(err_count), .last_bad(last_bad), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_cnt = 0; m_consec = 0; m_last = 0; m_flag = 0; m_fault = 0;
    end else begin
      bit rdy, acc, ok, pp;
      rdy = !m_fault && m_q.size() < 2;
      acc = in_valid && rdy;
      ok  = (in_word[3:2] ^ in_word[1:0]) == 2'b11;
      pp  = m_q.size() != 0 && out_ready;
      if (pp) void'(m_q.pop_front());
      if (acc && ok) m_q.push_back(int'(in_word[3:2]));
      if (clr_err) begin
        m_cnt = 0; m_consec = 0; m_last = 0; m_flag = 0; m_fault = 0;
      end else if (acc && ok) begin
        m_consec = 0;
      end else if (acc) begin
        m_flag = 1;
        m_last = int'(in_word);
        if (m_cnt < CMAX) m_cnt++;
        if (m_consec < THRESH) m_consec++;
        if (m_consec == THRESH) m_fault = 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, shortly after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        chk("in_ready",  32'(in_ready),  32'(!m_fault && m_q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("out_data", 32'(out_data), 32'(m_q[0]));
        chk("err_flag",  32'(err_flag),  32'(m_flag));
        chk("err_count", 32'(err_count), 32'(m_cnt));
        chk("last_bad",  32'(last_bad),  32'(m_last));
        chk("fault",     32'(fault),     32'(m_fault));
      end
    end
  end

  // Present a word from a negedge until accepted; returns at the following negedge.
  task automatic send(input logic [3:0] w);
    int waited = 0;
    in_valid = 1'b1;
    in_word  = w;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready stuck 0, required 1 for word %b", w);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_word = 4'h0; out_ready = 1'b0; clr_err = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_err_flag",  32'(err_flag),  32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_last_bad",  32'(last_bad),  32'd0);
    chk("rst_fault",     32'(fault),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Four valid words back-to-back, consumer always ready
    out_ready = 1'b1;
    send(4'b0011);
    chk("t1_first", 32'(out_data), 32'd0);
    send(4'b0110);
    chk("t1_second", 32'(out_data), 32'd1);
    send(4'b1001);
    chk("t1_third", 32'(out_data), 32'd2);
    send(4'b1100);
    chk("t1_fourth", 32'(out_data), 32'd3);
    @(negedge clk);
    chk("t1_err_flag", 32'(err_flag), 32'd0);

    // Backpressure fills the FIFO, then drains in order
    out_ready = 1'b0;
    send(4'b1001);
    send(4'b0110);
    chk("t2_full_ready", 32'(in_ready), 32'd0);
    chk("t2_head", 32'(out_data), 32'd2);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_ready_back", 32'(in_ready), 32'd1);
    chk("t2_second", 32'(out_data), 32'd1);
    @(negedge clk);
    chk("t2_empty", 32'(out_valid), 32'd0);

    // Single corrupted word followed by a good one
    send(4'b1010);
    chk("t3_no_output", 32'(out_valid), 32'd0);
    send(4'b1100);
    chk("t3_err_flag", 32'(err_flag), 32'd1);
    chk("t3_err_count", 32'(err_count), 32'd1);
    chk("t3_last_bad", 32'(last_bad), 32'hA);
    chk("t3_data", 32'(out_data), 32'd3);

    // Fault lockout after three consecutive errors, then clear
    pulse_clr();
    send(4'b0000);
    send(4'b0000);
    send(4'b0000);
    chk("t4_fault", 32'(fault), 32'd1);
    chk("t4_ready", 32'(in_ready), 32'd0);
    chk("t4_count", 32'(err_count), 32'd3);
    pulse_clr();
    chk("t4_fault_clr", 32'(fault), 32'd0);
    chk("t4_count_clr", 32'(err_count), 32'd0);
    chk("t4_ready_clr", 32'(in_ready), 32'd1);

    // A good word resets the consecutive run
    send(4'b1111);
    send(4'b0000);
    send(4'b0110);
    send(4'b1111);
    send(4'b0000);
    @(negedge clk);
    chk("t5_fault", 32'(fault), 32'd0);
    chk("t5_count", 32'(err_count), 32'd4);

    // Clear coinciding with an invalid accept: clear wins, word still consumed
    clr_err = 1'b1;
    send(4'b0101);
    clr_err = 1'b0;
    chk("t7_clr_wins", 32'(err_count), 32'd0);
    chk("t7_clr_flag", 32'(err_flag), 32'd0);

    // Reset in the middle of a full FIFO with errors recorded
    send(4'b0000); send(4'b0011); send(4'b0000); send(4'b0011);
    send(4'b0000); send(4'b0011); send(4'b0000); send(4'b0011);
    send(4'b1111);
    out_ready = 1'b0;
    send(4'b0011);
    send(4'b1100);
    chk("t6_pre_count", 32'(err_count), 32'd5);
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // Error counter saturation, interleaving good words to avoid fault
    for (int i = 0; i < 260; i++) begin
      send(4'b0000);
      send(4'b0011);
    end
    @(negedge clk);
    chk("t8_saturate", 32'(err_count), 32'(CMAX));
    chk("t8_no_fault", 32'(fault), 32'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
